// File: rtl/div_seq.sv
// Multi-cycle restoring divider for DIV/DIVU: one quotient bit per clock,
// stall request towards EX, {remainder, quotient} result with sign correction.
module div_seq #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic               annul_i,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o,
  output logic               stallreq_o
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {FREE, BYZERO, ON, END} state_e;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] dvsr_q;
  logic             sgn1_q;
  logic             sgn2_q;

  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;
  logic             no_borrow;
  logic [WIDTH-1:0] rem_d;
  logic [WIDTH-1:0] quo_d;
  logic             last_iter;

  function automatic logic [WIDTH-1:0] abs_val(input logic signed [WIDTH-1:0] v);
    return v[WIDTH-1] ? WIDTH'(-v) : WIDTH'(v);
  endfunction

  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic en);
    return en ? (~v + WIDTH'(1)) : v;
  endfunction

  assign stallreq_o = start_i & ~annul_i & ~ready_o;

  // quo_q starts as the dividend magnitude and fills with quotient bits from the bottom
  always_comb begin
    shifted   = {rem_q, quo_q[WIDTH-1]};
    diff      = shifted - {1'b0, dvsr_q};
    no_borrow = ~diff[WIDTH];
    rem_d     = no_borrow ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    quo_d     = {quo_q[WIDTH-2:0], no_borrow};
    last_iter = (cnt_q == CNT_W'(WIDTH - 1));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= FREE;
      cnt_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvsr_q   <= '0;
      sgn1_q   <= 1'b0;
      sgn2_q   <= 1'b0;
      ready_o  <= 1'b0;
      result_o <= '0;
    end else begin
      case (state_q)
        FREE: begin
          if (start_i && !annul_i) begin
            if (opdata2_i == '0) begin
              state_q <= BYZERO;
            end else begin
              state_q <= ON;
              quo_q   <= signed_div_i ? abs_val(opdata1_i) : opdata1_i;
              dvsr_q  <= signed_div_i ? abs_val(opdata2_i) : opdata2_i;
              sgn1_q  <= signed_div_i & opdata1_i[WIDTH-1];
              sgn2_q  <= signed_div_i & opdata2_i[WIDTH-1];
              cnt_q   <= '0;
              rem_q   <= '0;
            end
          end
        end
        BYZERO: begin
          if (annul_i) begin
            state_q <= FREE;
          end else begin
            state_q  <= END;
            ready_o  <= 1'b1;
            result_o <= '0;
          end
        end
        ON: begin
          if (annul_i) begin
            state_q <= FREE;
          end else begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            cnt_q <= cnt_q + CNT_W'(1);
            if (last_iter) begin
              state_q  <= END;
              ready_o  <= 1'b1;
              result_o <= {cond_neg(rem_d, sgn1_q), cond_neg(quo_d, sgn1_q ^ sgn2_q)};
            end
          end
        end
        END: begin
          if (!start_i) begin
            state_q  <= FREE;
            ready_o  <= 1'b0;
            result_o <= '0;
          end
        end
        default: state_q <= FREE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_seq.sv
// Directed bench for div_seq: scoreboard of expected {remainder, quotient},
// latency, stall, cancel and asynchronous reset behaviour.
module tb_div_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic        annul_i;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic [63:0] result_o;
  logic        ready_o;
  logic        stallreq_o;

  int n_cmp = 0;
  int n_err = 0;
  logic [63:0] exp_q[$];

  div_seq #(.WIDTH(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .result_o     (result_o),
    .ready_o      (ready_o),
    .stallreq_o   (stallreq_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic logic [63:0] model(input logic s, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] q, r;
    if (b == 32'd0) return 64'd0;
    if (!s) begin
      q = a / b;
      r = a % b;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000;
      r = 32'd0;
    end else begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end
    return {r, q};
  endfunction

  // Drives one division, scrambles operands after the start edge, waits for ready.
  task automatic do_div(input string tag, input logic s, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] expv,
                        input int lat, input bit drop);
    int edges;
    int stalls;
    logic [63:0] e;
    @(negedge clk);
    signed_div_i = s;
    opdata1_i    = a;
    opdata2_i    = b;
    start_i      = 1'b1;
    exp_q.push_back(expv);
    #1;
    chk({tag, "_stall_at_start"}, 64'(stallreq_o), 64'd1);
    edges  = 0;
    stalls = 1;
    while (!ready_o && edges < 100) begin
      @(posedge clk);
      #1;
      edges++;
      if (edges == 1) begin
        opdata1_i    = $urandom;
        opdata2_i    = $urandom;
        signed_div_i = ~s;
      end
      if (stallreq_o) stalls++;
    end
    chk({tag, "_latency"}, 64'(edges), 64'(lat));
    chk({tag, "_stall_cycles"}, 64'(stalls), 64'(lat));
    e = exp_q.pop_front();
    chk({tag, "_result"}, result_o, e);
    if (drop) begin
      start_i = 1'b0;
      @(posedge clk);
      #1;
      chk({tag, "_ready_clear"}, 64'(ready_o), 64'd0);
      chk({tag, "_result_clear"}, result_o, 64'd0);
    end
  endtask

  initial begin
    bit ok;
    logic [31:0] a, b;
    logic s;
    rst = 1'b0;
    start_i = 1'b0;
    annul_i = 1'b0;
    signed_div_i = 1'b0;
    opdata1_i = '0;
    opdata2_i = '0;
    #1;
    chk("reset_ready", 64'(ready_o), 64'd0);
    chk("reset_result", result_o, 64'd0);
    chk("reset_stall", 64'(stallreq_o), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    do_div("u100_7", 1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 33, 1'b1);
    do_div("s_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 33, 1'b1);
    do_div("s_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, {32'd1, 32'hFFFF_FFFD}, 33, 1'b1);
    do_div("s_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'd0, 32'h8000_0000}, 33, 1'b1);
    do_div("div0", 1'b0, 32'd5, 32'd0, 64'd0, 2, 1'b1);
    do_div("u_max_1", 1'b0, 32'hFFFF_FFFF, 32'd1, {32'd0, 32'hFFFF_FFFF}, 33, 1'b1);

    for (int i = 0; i < 6; i++) begin
      a = $urandom;
      b = $urandom >> $urandom_range(0, 31);
      s = i[0];
      do_div("rand", s, a, b, model(s, a, b), (b == 32'd0) ? 2 : 33, 1'b1);
    end

    // Cancel at iteration 10
    @(negedge clk);
    signed_div_i = 1'b0;
    opdata1_i = 32'd100;
    opdata2_i = 32'd7;
    start_i = 1'b1;
    repeat (11) @(posedge clk);
    #1;
    annul_i = 1'b1;
    #1;
    chk("annul_stall_drop", 64'(stallreq_o), 64'd0);
    @(posedge clk);
    #1;
    annul_i = 1'b0;
    start_i = 1'b0;
    ok = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (ready_o !== 1'b0) ok = 1'b0;
    end
    chk("annul_ready_stays_low", 64'(ok), 64'd1);
    do_div("after_annul_9_3", 1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 33, 1'b1);

    // Asynchronous reset at iteration 20
    @(negedge clk);
    opdata1_i = 32'd100;
    opdata2_i = 32'd7;
    start_i = 1'b1;
    repeat (21) @(posedge clk);
    #3;
    rst = 1'b0;
    start_i = 1'b0;
    #1;
    chk("rst_mid_ready", 64'(ready_o), 64'd0);
    chk("rst_mid_result", result_o, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    do_div("after_rst_9_3", 1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 33, 1'b1);

    // Asynchronous reset while holding a finished result
    do_div("hold_end", 1'b0, 32'd50, 32'd6, {32'd2, 32'd8}, 33, 1'b0);
    #3;
    rst = 1'b0;
    #1;
    chk("rst_end_ready", 64'(ready_o), 64'd0);
    chk("rst_end_result", result_o, 64'd0);
    start_i = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    do_div("final_9_3", 1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 33, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/div_seq.md
Name: div_seq

Overview:
- Multi-cycle restoring divider sequencer alongside the EX stage; executes DIV/DIVU one quotient bit per clock.
- Raises a stall request so the EX stage holds the instruction until the result is ready.
- Hands back {remainder, quotient} for the HI/LO write path.
- Owns operand capture, iteration count, sign correction, divide-by-zero handling and cancellation.

Parameters:
- WIDTH, 32, operand width; result is 2*WIDTH; iteration counter is clog2(WIDTH)+1 bits.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-low reset
- start_i  input  1  EX requests a division; held high until ready_o is seen
- annul_i  input  1  cancel the current/pending division (flush/exception)
- signed_div_i  input  1  1 = signed (DIV), 0 = unsigned (DIVU); sampled with start_i
- opdata1_i  input  WIDTH  dividend; sampled with start_i
- opdata2_i  input  WIDTH  divisor; sampled with start_i
- result_o  output  2*WIDTH  {remainder, quotient}; valid only while ready_o=1
- ready_o  output  1  result valid
- stallreq_o  output  1  combinational: start_i & ~annul_i & ~ready_o

Behaviour:
- Reset (rst=0, asynchronous): state=FREE, counter=0, ready_o=0, result_o=0. Takes effect immediately, including mid-division; the partial result is discarded.
- States: FREE, BYZERO, ON, END.
- FREE, no start (start_i=0 or annul_i=1): remain in FREE.
- FREE, start_i=1 and annul_i=0, divisor==0: go to BYZERO.
- FREE, start_i=1 and annul_i=0, divisor!=0: go to ON.
  - Capture |opdata1_i| and |opdata2_i| when signed_div_i=1; otherwise capture raw values.
  - Capture both operand sign bits; clear counter; clear the partial remainder.
- BYZERO: next edge goes to END with result 0; annul_i=1 goes to FREE instead.
- ON, per edge:
  - Shift one dividend bit into the partial remainder.
  - Trial-subtract the divisor; on no borrow, keep the difference and set quotient bit 1; otherwise set quotient bit 0.
  - Increment the counter.
  - When the WIDTH-th iteration completes, go to END and apply sign correction.
- Sign correction (signed only):
  - Quotient is negated if dividend sign xor divisor sign.
  - Remainder is negated if the dividend was negative.
  - Unsigned: no correction.
- Width rule: most-negative / -1 yields quotient 0x80000000 (two's-complement wrap), remainder 0, with no error flag.
- annul_i=1 in ON: go to FREE on the next edge; ready_o never rises.
- END: ready_o=1 and result_o holds. If start_i=0, go to FREE on the next edge, clearing ready_o and result_o. If start_i=1, stay in END (handshake: EX drops start_i after consuming). annul_i is ignored in END.
- Latency, normal: start sampled at edge E0; ready_o=1 after edge E(WIDTH+1), i.e. 33 edges for WIDTH=32.
- Latency, divide-by-zero: ready_o=1 after E2.
- stallreq_o stays high from start_i assertion until ready_o=1, and is low in FREE when start_i=0.
- Operand changes after E0 are ignored.
- start_i deasserted in ON/BYZERO without annul is illegal; the division completes, END is entered, then exits to FREE on the next edge.

Test Plan:
- Unsigned: 100 / 7, start held high.
  - ready_o rises after exactly 33 edges.
  - result_o = {32'd2, 32'd14}.
  - stallreq_o high for 33 cycles.
  - Drop start_i: FREE next edge, result_o=0.
- Signed: -7 / 2 → quotient 0xFFFFFFFD, remainder 0xFFFFFFFF.
- Signed: 7 / -2 → quotient 0xFFFFFFFD, remainder 1.
- Signed overflow: 0x80000000 / 0xFFFFFFFF → quotient 0x80000000, remainder 0, same 33-edge latency.
- Divide by zero: 5 / 0 → ready_o after 2 edges, result_o=0.
- Unsigned: 0xFFFFFFFF / 1 → quotient 0xFFFFFFFF, remainder 0.
- Cancel: annul_i pulsed at iteration 10 → FREE next edge, ready_o stays 0, stallreq_o drops while annul_i=1. A new start of 9/3 then gives {0, 3} after 33 edges.
- Reset: rst low at iteration 20 → outputs 0 immediately without a clock edge. After release, start 9/3 gives a correct result.
